// File: rtl/isqrt_pipe.sv
// Fully pipelined floor(sqrt(x)): one root bit resolved per stage, N = WIDTH/2 stages.
// Stage data registers load only when a valid operand enters them; only the valid chain and y reset.
module isqrt_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_vld,
  input  logic [WIDTH-1:0] x,
  output logic             y_vld,
  output logic [WIDTH-1:0] y
);

  localparam int N  = WIDTH / 2;
  localparam int W1 = WIDTH + 1;

  // Stage k inputs (from x or from stage k-1 registers) and next-state values.
  logic [WIDTH-1:0]        rem_in  [N];
  logic [N-1:0]            root_in [N];
  logic                    vld_in  [N];
  logic [W1-1:0]           trial   [N];
  logic signed [W1-1:0]    diff    [N];
  logic [N-1:0]            root_nx [N];
  logic [WIDTH-1:0]        rem_nx  [N-1];

  // Registers of stages 0..N-2; stage N-1 lands directly in the output register.
  logic [WIDTH-1:0]        rem_p   [N-1];
  logic [N-1:0]            root_p  [N-1];
  logic [N-1:0]            vld_p;
  logic [N-1:0]            y_root;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      if (k == 0) begin
        rem_in[k]  = x;
        root_in[k] = '0;
        vld_in[k]  = x_vld;
      end else begin
        rem_in[k]  = rem_p[k-1];
        root_in[k] = root_p[k-1];
        vld_in[k]  = vld_p[k-1];
      end
      // Subtracting (4r+1) << 2i tests whether root bit i can be set; the sign decides.
      trial[k]   = W1'({root_in[k], 2'b01}) << (2 * (N - 1 - k));
      diff[k]    = $signed({1'b0, rem_in[k]}) - $signed(trial[k]);
      root_nx[k] = {root_in[k][N-2:0], ~diff[k][W1-1]};
    end
    for (int k = 0; k < N - 1; k++) begin
      rem_nx[k] = diff[k][W1-1] ? rem_in[k] : diff[k][WIDTH-1:0];
    end
  end

  // Valid chain: plain shift register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) vld_p <= '0;
    else     vld_p <= {vld_p[N-2:0], x_vld};
  end

  // Stage data: hold unless a valid operand is entering the stage.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N - 1; k++) begin
      if (vld_in[k]) begin
        rem_p[k]  <= rem_nx[k];
        root_p[k] <= root_nx[k];
      end
    end
  end

  // Output stage: last root bit resolved straight into y.
  always_ff @(posedge clk) begin
    if (rst)                y_root <= '0;
    else if (vld_in[N-1])   y_root <= root_nx[N-1];
  end

  assign y_vld = vld_p[N-1];
  assign y     = {{(WIDTH - N){1'b0}}, y_root};

endmodule
